// File: rtl/y86_pipe_execute.sv
// Y86-64 pipelined execute stage: ALU, exception-gated condition codes, Cnd
// evaluation for cmovXX/jXX, cmov destination squash and the E->M register.
module y86_pipe_execute #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned WORD_BYTES = 8,
  parameter logic [3:0]  RNONE      = 4'hF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       e_stat,
  input  logic [3:0]       e_icode,
  input  logic [3:0]       e_ifun,
  input  logic [WIDTH-1:0] e_valA,
  input  logic [WIDTH-1:0] e_valB,
  input  logic [WIDTH-1:0] e_valC,
  input  logic [3:0]       e_dstE,
  input  logic [3:0]       e_dstM,
  input  logic             down_exc,
  input  logic             m_stall,
  input  logic             m_bubble,
  output logic [WIDTH-1:0] fwd_valE,
  output logic [3:0]       fwd_dstE,
  output logic [2:0]       cc,
  output logic [3:0]       M_stat,
  output logic [3:0]       M_icode,
  output logic             M_Cnd,
  output logic [WIDTH-1:0] M_valE,
  output logic [WIDTH-1:0] M_valA,
  output logic [3:0]       M_dstE,
  output logic [3:0]       M_dstM
);

  typedef enum logic [3:0] {
    I_HALT, I_NOP, I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
    I_OPQ, I_JXX, I_CALL, I_RET, I_PUSHQ, I_POPQ
  } icode_e;

  localparam logic [3:0] STAT_AOK = 4'h1;

  logic [WIDTH-1:0] alu_a, alu_b, alu_r;
  logic [3:0]       alu_fun;
  logic             zf_n, sf_n, of_n;
  logic [2:0]       cc_q, cc_d;
  logic             cnd;
  logic             zf, sf, ovf;

  logic [3:0]       m_stat_q, m_stat_d, m_icode_q, m_icode_d;
  logic             m_cnd_q, m_cnd_d;
  logic [WIDTH-1:0] m_valE_q, m_valE_d, m_valA_q, m_valA_d;
  logic [3:0]       m_dstE_q, m_dstE_d, m_dstM_q, m_dstM_d;

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (e_icode)
      I_RRMOVQ, I_OPQ:             alu_a = e_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = e_valC;
      I_CALL, I_PUSHQ:             alu_a = '0 - WIDTH'(WORD_BYTES);
      I_RET, I_POPQ:               alu_a = WIDTH'(WORD_BYTES);
      default:                     alu_a = '0;
    endcase
    case (e_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = e_valB;
      default: alu_b = '0;
    endcase
  end

  always_comb begin
    alu_fun = (e_icode == I_OPQ) ? e_ifun : 4'h0;
    alu_r   = '0;
    of_n    = 1'b0;
    case (alu_fun)
      4'h0: begin
        alu_r = alu_b + alu_a;
        of_n  = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (alu_r[WIDTH-1] != alu_b[WIDTH-1]);
      end
      4'h1: begin
        alu_r = alu_b - alu_a;
        of_n  = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (alu_r[WIDTH-1] != alu_b[WIDTH-1]);
      end
      4'h2:    alu_r = alu_b & alu_a;
      4'h3:    alu_r = alu_b ^ alu_a;
      default: alu_r = '0;
    endcase
    zf_n = (alu_r == '0);
    sf_n = alu_r[WIDTH-1];
  end

  // Cnd looks at the registered flags, i.e. before this cycle's OPq update.
  assign zf  = cc_q[2];
  assign sf  = cc_q[1];
  assign ovf = cc_q[0];

  always_comb begin
    cnd = 1'b0;
    if (e_icode == I_RRMOVQ || e_icode == I_JXX) begin
      case (e_ifun)
        4'h0:    cnd = 1'b1;
        4'h1:    cnd = (sf ^ ovf) | zf;
        4'h2:    cnd = sf ^ ovf;
        4'h3:    cnd = zf;
        4'h4:    cnd = ~zf;
        4'h5:    cnd = ~(sf ^ ovf);
        4'h6:    cnd = ~(sf ^ ovf) & ~zf;
        default: cnd = 1'b0;
      endcase
    end
  end

  assign fwd_valE = alu_r;
  assign fwd_dstE = (e_icode == I_RRMOVQ && !cnd) ? RNONE : e_dstE;
  assign cc       = cc_q;

  always_comb begin
    cc_d = cc_q;
    if (e_icode == I_OPQ && e_ifun <= 4'h3 && e_stat == STAT_AOK && !down_exc && !m_stall)
      cc_d = {zf_n, sf_n, of_n};
  end

  always_comb begin
    m_stat_d  = m_stat_q;
    m_icode_d = m_icode_q;
    m_cnd_d   = m_cnd_q;
    m_valE_d  = m_valE_q;
    m_valA_d  = m_valA_q;
    m_dstE_d  = m_dstE_q;
    m_dstM_d  = m_dstM_q;
    if (!m_stall) begin
      if (m_bubble) begin
        m_stat_d  = STAT_AOK;
        m_icode_d = I_NOP;
        m_cnd_d   = 1'b0;
        m_valE_d  = '0;
        m_valA_d  = '0;
        m_dstE_d  = RNONE;
        m_dstM_d  = RNONE;
      end else begin
        m_stat_d  = e_stat;
        m_icode_d = e_icode;
        m_cnd_d   = cnd;
        m_valE_d  = alu_r;
        m_valA_d  = e_valA;
        m_dstE_d  = fwd_dstE;
        m_dstM_d  = e_dstM;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc_q      <= 3'b100;
      m_stat_q  <= STAT_AOK;
      m_icode_q <= I_NOP;
      m_cnd_q   <= 1'b0;
      m_valE_q  <= '0;
      m_valA_q  <= '0;
      m_dstE_q  <= RNONE;
      m_dstM_q  <= RNONE;
    end else begin
      cc_q      <= cc_d;
      m_stat_q  <= m_stat_d;
      m_icode_q <= m_icode_d;
      m_cnd_q   <= m_cnd_d;
      m_valE_q  <= m_valE_d;
      m_valA_q  <= m_valA_d;
      m_dstE_q  <= m_dstE_d;
      m_dstM_q  <= m_dstM_d;
    end
  end

  assign M_stat  = m_stat_q;
  assign M_icode = m_icode_q;
  assign M_Cnd   = m_cnd_q;
  assign M_valE  = m_valE_q;
  assign M_valA  = m_valA_q;
  assign M_dstE  = m_dstE_q;
  assign M_dstM  = m_dstM_q;

endmodule

// File: doc/y86_pipe_execute.md
Name: y86_pipe_execute

Overview:
- Execute (E) stage of the pipelined Y86-64 core, width-parametrised; successor of the single-cycle execute stage.
- Contains ALU operand select, ALU, a condition-code register with exception-gated update, and the Cnd evaluator for cmovXX/jXX.
- Adds the E→M pipeline register with stall/bubble control and cmov destination squashing.
- Drives combinational forwarding values back to decode.

Parameters:
- WIDTH, 64: datapath width in bits (valA/valB/valC/valE).
- WORD_BYTES, 8: stack adjust constant for call/ret/push/pop.
- RNONE, 4'hF: register ID meaning "no register".

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- e_stat  in  4  stat of instruction in E (1 AOK, 2 HLT, 3 ADR, 4 INS).
- e_icode  in  4  instruction code.
- e_ifun  in  4  function code.
- e_valA  in  WIDTH  operand A.
- e_valB  in  WIDTH  operand B.
- e_valC  in  WIDTH  immediate.
- e_dstE  in  4  ALU destination register ID.
- e_dstM  in  4  memory destination register ID.
- down_exc  in  1  M or W stage holds a non-AOK stat.
- m_stall  in  1  hold the M register.
- m_bubble  in  1  load a nop into the M register.
- fwd_valE  out  WIDTH  combinational ALU result.
- fwd_dstE  out  4  combinational dstE after cmov squash.
- cc  out  3  {ZF,SF,OF} register.
- M_stat  out  4  registered stat.
- M_icode  out  4  registered icode.
- M_Cnd  out  1  registered Cnd.
- M_valE  out  WIDTH  registered ALU result.
- M_valA  out  WIDTH  registered valA.
- M_dstE  out  4  registered dstE.
- M_dstM  out  4  registered dstM.

Behaviour:

ALU operand A by icode:
- 2, 6: valA.
- 3, 4, 5: valC.
- 8, A: −WORD_BYTES (two's complement, WIDTH bits).
- 9, B: +WORD_BYTES.
- All others: 0.

ALU operand B by icode:
- 4, 5, 6, 8, 9, A, B: valB.
- All others: 0.

ALU function and result:
- alu_fun = e_ifun when icode==6, otherwise 0 (add).
- Results: 0 → B+A, 1 → B−A, 2 → B&A, 3 → B^A, 4..F → 0.
- All arithmetic is modulo 2^WIDTH; there is no carry output.

Flag computation (MSB = bit WIDTH−1):
- OF for add: A.msb==B.msb and R.msb≠B.msb.
- OF for sub: A.msb≠B.msb and R.msb≠B.msb.
- OF for and/xor: 0.
- ZF = (R==0). SF = R.msb.

CC register:
- Reset value: ZF=1, SF=0, OF=0.
- Updates on a clock edge only when all of the following hold: icode==6, ifun≤3, e_stat==AOK, down_exc==0, m_stall==0.
- Otherwise it holds. A stalled OPq therefore updates CC exactly once, on the cycle it advances.

Cnd (combinational from the current cc register, before that cycle's update):
- Evaluated only for icode 2 or 7.
- ifun 0 → 1
- ifun 1 → (SF^OF)|ZF
- ifun 2 → SF^OF
- ifun 3 → ZF
- ifun 4 → ~ZF
- ifun 5 → ~(SF^OF)
- ifun 6 → ~(SF^OF)&~ZF
- ifun 7..F → 0.
- Cnd=0 for every other icode.

Forwarding outputs:
- fwd_dstE = RNONE when icode==2 and Cnd==0, otherwise e_dstE.
- fwd_valE = ALU result.

M register update, each rising edge:
- rst asserted (asynchronous, any time): load the nop image. Stat=AOK, icode=1, Cnd=0, valE=0, valA=0, dstE=dstM=RNONE. CC returns to reset value. Mid-stall state is discarded.
- m_stall=1: hold all M outputs. Stall has priority over bubble.
- Else m_bubble=1: load the nop image.
- Else: load e_stat, e_icode, Cnd, ALU result, e_valA, fwd_dstE, e_dstM.

Latency:
- fwd_* are zero-cycle.
- M_* are valid one cycle after E inputs are presented.

Test Plan:
- Reset then `OPq addq` (icode 6, ifun 0), valA=1, valB=0x7FFF_FFFF_FFFF_FFFF → after 1 edge M_valE=0x8000_0000_0000_0000, cc={0,1,1}.
- `subq` with valA=5, valB=5 → M_valE=0, cc={1,0,0}. Then `cmovle` (icode 2, ifun 1), e_dstE=3 → fwd_dstE=3, M_Cnd=1.
- cc={0,0,0}, `cmove` (icode 2, ifun 3), e_dstE=3 → fwd_dstE=4'hF, M_dstE=4'hF, M_Cnd=0.
- `OPq xorq` with down_exc=1, valA=valB=7 → M_valE=0, cc unchanged at {0,0,0}.
- `OPq subq` held for 3 cycles with m_stall=1 → M outputs hold and cc holds. Release stall → one CC update, M_valE loaded once.
- `pushq` (icode A), valB=0x100 → M_valE=0xF8. `ret` (icode 9), valB=0xF8 → M_valE=0x100. Assert m_bubble → M_icode=1, M_dstE=4'hF. Assert rst mid-sequence → M returns to the nop image and cc={1,0,0} immediately, without waiting for a clock edge.
